pipe_seq_ctl: RTL and testbench

//  Sequencer for the chain of pipeline stage registers (PSRs) between processor stages.

---
 rtl/pipe_seq_ctl_pkg.sv | 18 +
 rtl/pipe_seq_ctl_adv_counter.sv | 19 +
 rtl/pipe_seq_ctl.sv | 119 +++++++++++
 tb/tb_pipe_seq_ctl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pipe_seq_ctl_pkg.sv
// Shared definitions for the PSR sequencer: state encoding and default pipeline geometry.
package pipe_seq_ctl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_e;

  localparam int unsigned NUM_PSR_DEF  = 3;
  localparam int unsigned HZ_STAGE_DEF = 1;
  localparam int unsigned FLUSH_N_DEF  = 2;
  localparam int unsigned CNT_W_DEF    = 16;

endpackage

// File: rtl/pipe_seq_ctl_adv_counter.sv
// Wrapping advance counter with asynchronous active-low clear and increment enable.
module seq_adv_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_seq_ctl.sv
// Sequencer for the pipeline stage register chain: two-phase advance, hazard bubbles,
// Ri-only reload, branch flush and halt.
module pipe_seq_ctl
  import pipe_seq_ctl_pkg::*;
#(
  parameter int unsigned NUM_PSR  = NUM_PSR_DEF,
  parameter int unsigned HZ_STAGE = HZ_STAGE_DEF,
  parameter int unsigned FLUSH_N  = FLUSH_N_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic               halt,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic               ri_reload,
  output logic [NUM_PSR-1:0] c_left,
  output logic [NUM_PSR-1:0] c_right,
  output logic [NUM_PSR-1:0] ld_ri,
  output logic [NUM_PSR-1:0] psr_clr_n,
  output logic               busy,
  output logic [CNT_W-1:0]   adv_cnt
);

  seq_state_e         state, st_nxt;
  logic               hz_q, ri_q, hz_nxt, ri_nxt;
  logic [NUM_PSR-1:0] left_nxt, right_nxt, ldri_nxt, clrn_nxt;
  logic               busy_nxt;

  always_comb begin
    st_nxt = state;
    hz_nxt = hz_q;
    ri_nxt = ri_q;
    unique case (state)
      ST_INIT:  st_nxt = ST_IDLE;
      ST_IDLE:  st_nxt = run ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        st_nxt = ST_SHIFT;
        hz_nxt = hazard;
        ri_nxt = ri_reload;
      end
      ST_SHIFT: begin
        if (halt)              st_nxt = ST_HALTED;
        else if (branch_taken) st_nxt = ST_FLUSH;
        else if (run)          st_nxt = ST_LOAD;
        else                   st_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        st_nxt = run ? ST_LOAD : ST_IDLE;
        hz_nxt = 1'b0;
        ri_nxt = 1'b0;
      end
      ST_HALTED: st_nxt = ST_HALTED;
      default:   st_nxt = ST_INIT;
    endcase
  end

  // Outputs are decoded from the state/qualifiers being entered and then registered,
  // so they line up with the state register and hold their reset values while clr is low.
  always_comb begin
    left_nxt  = '0;
    right_nxt = '0;
    ldri_nxt  = '0;
    clrn_nxt  = '1;
    busy_nxt  = !(st_nxt inside {ST_IDLE, ST_HALTED});
    for (int unsigned i = 0; i < NUM_PSR; i++) begin
      unique case (st_nxt)
        ST_INIT:  clrn_nxt[i]  = 1'b0;
        ST_LOAD:  left_nxt[i]  = !hz_nxt || (i >= HZ_STAGE);
        ST_SHIFT: begin
          right_nxt[i] = !hz_nxt || (i > HZ_STAGE);
          if (hz_nxt && (i == HZ_STAGE)) clrn_nxt[i] = 1'b0;
        end
        ST_FLUSH: clrn_nxt[i]  = (i >= FLUSH_N);
        default:  ;
      endcase
    end
    if (st_nxt == ST_LOAD && ri_nxt) begin
      ldri_nxt[0] = 1'b1;
      left_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_INIT;
      hz_q      <= 1'b0;
      ri_q      <= 1'b0;
      c_left    <= '0;
      c_right   <= '0;
      ld_ri     <= '0;
      psr_clr_n <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= st_nxt;
      hz_q      <= hz_nxt;
      ri_q      <= ri_nxt;
      c_left    <= left_nxt;
      c_right   <= right_nxt;
      ld_ri     <= ldri_nxt;
      psr_clr_n <= clrn_nxt;
      busy      <= busy_nxt;
    end
  end

  seq_adv_counter #(.CNT_W(CNT_W)) u_adv_counter (
    .clk (clk),
    .clr (clr),
    .inc (state == ST_SHIFT),
    .cnt (adv_cnt)
  );

  a_left_ri_excl: assert property (@(posedge clk) disable iff (!clr)
    (c_left & ld_ri) == '0);
  a_en_clr_excl: assert property (@(posedge clk) disable iff (!clr)
    ((c_left | c_right | ld_ri) & ~psr_clr_n) == '0);

endmodule

// File: tb/tb_pipe_seq_ctl.sv
// Directed-vector bench for pipe_seq_ctl; a narrow-counter instance covers the wrap case.
module tb_pipe_seq_ctl;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        run = 1'b0, halt = 1'b0, hazard = 1'b0, branch_taken = 1'b0, ri_reload = 1'b0;
  logic [2:0]  c_left, c_right, ld_ri, psr_clr_n;
  logic        busy;
  logic [15:0] adv_cnt;
  logic [2:0]  w_left, w_right, w_ldri, w_clrn;
  logic        w_busy;
  logic [3:0]  w_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_seq_ctl dut (
    .clk(clk), .clr(clr), .run(run), .halt(halt), .hazard(hazard),
    .branch_taken(branch_taken), .ri_reload(ri_reload),
    .c_left(c_left), .c_right(c_right), .ld_ri(ld_ri), .psr_clr_n(psr_clr_n),
    .busy(busy), .adv_cnt(adv_cnt)
  );

  pipe_seq_ctl #(.CNT_W(4)) dut_w (
    .clk(clk), .clr(clr), .run(run), .halt(halt), .hazard(hazard),
    .branch_taken(branch_taken), .ri_reload(ri_reload),
    .c_left(w_left), .c_right(w_right), .ld_ri(w_ldri), .psr_clr_n(w_clrn),
    .busy(w_busy), .adv_cnt(w_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] l, input logic [2:0] r,
                            input logic [2:0] ri, input logic [2:0] cn, input logic b);
    check({tag, ".c_left"},    32'(c_left),    32'(l));
    check({tag, ".c_right"},   32'(c_right),   32'(r));
    check({tag, ".ld_ri"},     32'(ld_ri),     32'(ri));
    check({tag, ".psr_clr_n"}, 32'(psr_clr_n), 32'(cn));
    check({tag, ".busy"},      32'(busy),      32'(b));
  endtask

  initial begin
    // Reset values
    #2;
    check_outs("rst", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    check("rst.adv_cnt", 32'(adv_cnt), 32'd0);

    // 1: free-running advance
    run = 1'b1;
    step(2);
    check_outs("init_hold", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    @(negedge clk) clr = 1'b1;
    step(1);
    check_outs("idle", 3'b000, 3'b000, 3'b000, 3'b111, 1'b0);
    step(1);
    check_outs("load1", 3'b111, 3'b000, 3'b000, 3'b111, 1'b1);
    step(1);
    check_outs("shift1", 3'b000, 3'b111, 3'b000, 3'b111, 1'b1);
    step(7);
    check("t1.adv_cnt", 32'(adv_cnt), 32'd4);
    check("t1.c_left", 32'(c_left), 32'b111);

    // 2: hazard captured in this LOAD
    hazard = 1'b1;
    step(1);
    hazard = 1'b0;
    check_outs("hz_shift", 3'b000, 3'b100, 3'b000, 3'b101, 1'b1);
    step(1);
    check_outs("hz_load", 3'b110, 3'b000, 3'b000, 3'b111, 1'b1);
    check("t2.adv_cnt", 32'(adv_cnt), 32'd5);
    step(1);
    check_outs("hz_after", 3'b000, 3'b111, 3'b000, 3'b111, 1'b1);

    // 3: hazard and branch in the same advance; FLUSH drops the hazard
    step(1);
    hazard = 1'b1;
    step(1);
    hazard = 1'b0;
    branch_taken = 1'b1;
    check("t3.hz_right", 32'(c_right), 32'b100);
    step(1);
    branch_taken = 1'b0;
    check_outs("flush", 3'b000, 3'b000, 3'b000, 3'b100, 1'b1);
    check("t3.adv_cnt", 32'(adv_cnt), 32'd7);
    step(1);
    check_outs("post_flush", 3'b111, 3'b000, 3'b000, 3'b111, 1'b1);

    // 4: Ri-only reload requested in this LOAD
    ri_reload = 1'b1;
    step(1);
    ri_reload = 1'b0;
    check("t4.shift_right", 32'(c_right), 32'b111);
    step(1);
    check_outs("ri_load", 3'b110, 3'b000, 3'b001, 3'b111, 1'b1);
    check("t4.bit0_excl", 32'(c_left[0] & ld_ri[0]), 32'd0);
    step(2);
    check_outs("ri_after", 3'b111, 3'b000, 3'b000, 3'b111, 1'b1);

    // 5: halt beats branch
    step(1);
    halt = 1'b1;
    branch_taken = 1'b1;
    step(1);
    halt = 1'b0;
    branch_taken = 1'b0;
    check_outs("halted", 3'b000, 3'b000, 3'b000, 3'b111, 1'b0);
    step(3);
    check_outs("halt_hold", 3'b000, 3'b000, 3'b000, 3'b111, 1'b0);
    check("t5.adv_cnt", 32'(adv_cnt), 32'd10);
    @(negedge clk) clr = 1'b0;
    #1;
    check("t5.rst_cnt", 32'(adv_cnt), 32'd0);
    check("t5.rst_clrn", 32'(psr_clr_n), 32'd0);

    // 6: counter wrap on the 4-bit instance, then reset mid-SHIFT
    @(negedge clk) clr = 1'b1;
    step(32);
    check("t6.w_cnt15", 32'(w_cnt), 32'd15);
    check("t6.w_load", 32'(w_left), 32'b111);
    step(1);
    check("t6.w_shift", 32'(w_right), 32'b111);
    step(1);
    check("t6.w_wrap", 32'(w_cnt), 32'd0);
    check("t6.cnt16", 32'(adv_cnt), 32'd16);
    step(1);
    check("t6.pre_rst_right", 32'(c_right), 32'b111);
    @(negedge clk) clr = 1'b0;
    #1;
    check_outs("mid_shift_rst", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    check("t6.rst_cnt", 32'(adv_cnt), 32'd0);
    check("t6.rst_w_right", 32'(w_right), 32'd0);
    check("t6.rst_w_cnt", 32'(w_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
